// File: rtl/lemon_rf_pkg.sv
// rtl/lemon_rf_pkg.sv - shared constants and bus slicing helpers for the register file
package lemon_rf_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int ZERO_IDX       = 0;

  // LSB position of port p inside a flattened bus of per-port fields of width w.
  function automatic int port_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// rtl/rf_bypass_mux.sv - one read port: write-first bypass over all write ports, zero forcing
module rf_bypass_mux
  import lemon_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NW         = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [NW-1:0]            wen,
  input  logic [NW*ADDR_WIDTH-1:0] rd,
  input  logic [NW*DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0]    rf_data,
  output logic [DATA_WIDTH-1:0]    data
);

  // Ascending scan so the highest-index matching port overrides lower ones.
  always_comb begin
    data = rf_data;
    for (int j = 0; j < NW; j++) begin
      if (wen[j] && rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH] == addr)
        data = wdata[port_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
    end
    if (ZERO_REG != 0 && addr == ADDR_WIDTH'(ZERO_IDX))
      data = '0;
  end

endmodule

// File: rtl/regfile_multiport_sb.sv
// rtl/regfile_multiport_sb.sv - multiport register file with bypass, busy scoreboard and debug change stream
module regfile_multiport_sb
  import lemon_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR         = 2,
  parameter int NW         = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NR*ADDR_WIDTH-1:0] rs_addr,
  output logic [NR*DATA_WIDTH-1:0] rs_data,
  output logic [NR-1:0]            rs_busy,
  input  logic [NW-1:0]            wen,
  input  logic [NW*ADDR_WIDTH-1:0] rd,
  input  logic [NW*DATA_WIDTH-1:0] dataD,
  input  logic                     alloc_valid,
  input  logic [ADDR_WIDTH-1:0]    alloc_rd,
  input  logic                     flush,
  output logic [NW-1:0]            dbg_valid,
  output logic [NW*ADDR_WIDTH-1:0] dbg_rd,
  output logic [NW*DATA_WIDTH-1:0] dbg_old,
  output logic [NW*DATA_WIDTH-1:0] dbg_new
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]       busy, busy_nxt;
  logic [NW-1:0]         win;

  // A port wins only if no higher port targets the same register this cycle.
  always_comb begin
    win = '0;
    for (int j = 0; j < NW; j++) begin
      win[j] = wen[j];
      if (ZERO_REG != 0 && rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_IDX))
        win[j] = 1'b0;
      for (int k = j + 1; k < NW; k++) begin
        if (wen[k] && rd[port_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH] ==
                      rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH])
          win[j] = 1'b0;
      end
    end
  end

  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (wen[j]) busy_nxt[rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b0;
    end
    if (alloc_valid) busy_nxt[alloc_rd] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
      busy      <= '0;
      dbg_valid <= '0;
      dbg_rd    <= '0;
      dbg_old   <= '0;
      dbg_new   <= '0;
    end else begin
      busy <= busy_nxt;
      for (int j = 0; j < NW; j++) begin
        dbg_valid[j] <= win[j] && (dataD[port_lsb(j, DATA_WIDTH) +: DATA_WIDTH] !=
                                   rf[rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH]]);
        dbg_rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH]  <= rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH];
        dbg_old[port_lsb(j, DATA_WIDTH) +: DATA_WIDTH] <= rf[rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH]];
        dbg_new[port_lsb(j, DATA_WIDTH) +: DATA_WIDTH] <= dataD[port_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
        if (win[j])
          rf[rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH]] <= dataD[port_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic                  hit;
    assign a = rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    rf_bypass_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NW         (NW),
      .ZERO_REG   (ZERO_REG)
    ) u_mux (
      .addr    (a),
      .wen     (wen),
      .rd      (rd),
      .wdata   (dataD),
      .rf_data (rf[a]),
      .data    (rs_data[i*DATA_WIDTH +: DATA_WIDTH])
    );

    // A same-cycle writeback releases the source before the busy register updates.
    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < NW; j++)
        if (wen[j] && rd[port_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH] == a) hit = 1'b1;
    end

    assign rs_busy[i] = busy[a] & ~hit & ~flush &
                        ~(ZERO_REG != 0 && a == ADDR_WIDTH'(ZERO_IDX));
  end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// tb/tb_regfile_multiport_sb.sv - directed self-checking bench for regfile_multiport_sb (NR=2, NW=2)
module tb_regfile_multiport_sb;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] a0, a1, rd0, rd1, alloc_rd;
  logic [DW-1:0] d0, d1;
  logic [1:0]    w_en;
  logic          alloc_valid, flush;

  logic [2*DW-1:0] rs_data;
  logic [1:0]      rs_busy;
  logic [1:0]      dbg_valid;
  logic [2*AW-1:0] dbg_rd;
  logic [2*DW-1:0] dbg_old, dbg_new;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_multiport_sb #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NR (2), .NW (2), .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs_addr     ({a1, a0}),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .wen         (w_en),
    .rd          ({rd1, rd0}),
    .dataD       ({d1, d0}),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .flush       (flush),
    .dbg_valid   (dbg_valid),
    .dbg_rd      (dbg_rd),
    .dbg_old     (dbg_old),
    .dbg_new     (dbg_new)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en = 2'b00; alloc_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    a0 = '0; a1 = '0; rd0 = '0; rd1 = '0; d0 = '0; d1 = '0; alloc_rd = '0;
    step(); step();
    rst_n = 1'b1;

    // Populate some state, then reset on top of active writes/alloc
    w_en = 2'b11; rd0 = 5'd1; d0 = 64'h1111; rd1 = 5'd2; d1 = 64'h2222;
    alloc_valid = 1'b1; alloc_rd = 5'd2;
    step();
    rst_n = 1'b0; w_en = 2'b01; rd0 = 5'd1; d0 = 64'h9999; alloc_rd = 5'd1;
    step();
    rst_n = 1'b1; idle(); a0 = 5'd1; a1 = 5'd2; #1;
    check("rst_data0", rs_data[63:0], 64'h0);
    check("rst_data1", rs_data[127:64], 64'h0);
    check("rst_busy", {62'd0, rs_busy}, 64'h0);
    check("rst_dbg", {62'd0, dbg_valid}, 64'h0);

    // Bypass
    w_en = 2'b01; rd0 = 5'd5; d0 = 64'hDEAD; a0 = 5'd5; #1;
    check("byp_same", rs_data[63:0], 64'hDEAD);
    step(); idle(); #1;
    check("byp_next", rs_data[63:0], 64'hDEAD);
    check("byp_dbgv", {62'd0, dbg_valid}, 64'h1);
    check("byp_dbgnew", dbg_new[63:0], 64'hDEAD);
    check("byp_dbgold", dbg_old[63:0], 64'h0);

    // Two ports to x7: higher port wins
    w_en = 2'b11; rd0 = 5'd7; d0 = 64'h11; rd1 = 5'd7; d1 = 64'h22; a1 = 5'd7; #1;
    check("conf_byp", rs_data[127:64], 64'h22);
    step(); idle(); #1;
    check("conf_rf", rs_data[127:64], 64'h22);
    check("conf_dbgv", {62'd0, dbg_valid}, 64'h2);
    check("conf_dbgnew", dbg_new[127:64], 64'h22);
    check("conf_dbgrd", {59'd0, dbg_rd[9:5]}, 64'd7);

    // Same value rewrite produces no debug event
    w_en = 2'b01; rd0 = 5'd7; d0 = 64'h22;
    step(); idle(); #1;
    check("same_dbgv", {62'd0, dbg_valid}, 64'h0);

    // Zero register
    w_en = 2'b01; rd0 = 5'd0; d0 = 64'hFFFF; alloc_valid = 1'b1; alloc_rd = 5'd0; a0 = 5'd0; #1;
    check("x0_byp", rs_data[63:0], 64'h0);
    check("x0_busy_c", {63'd0, rs_busy[0]}, 64'h0);
    step(); idle(); #1;
    check("x0_rf", rs_data[63:0], 64'h0);
    check("x0_busy", {63'd0, rs_busy[0]}, 64'h0);
    check("x0_dbgv", {62'd0, dbg_valid}, 64'h0);

    // Scoreboard on x3
    alloc_valid = 1'b1; alloc_rd = 5'd3; a0 = 5'd3;
    step(); idle(); #1;
    check("sb_alloc", {63'd0, rs_busy[0]}, 64'h1);
    w_en = 2'b01; rd0 = 5'd3; d0 = 64'h33; alloc_valid = 1'b1; alloc_rd = 5'd3; #1;
    check("sb_wbal_c", {63'd0, rs_busy[0]}, 64'h0);
    step(); idle(); #1;
    check("sb_wbal", {63'd0, rs_busy[0]}, 64'h1);
    w_en = 2'b01; rd0 = 5'd3; d0 = 64'h34; #1;
    check("sb_wb_c", {63'd0, rs_busy[0]}, 64'h0);
    step(); idle(); #1;
    check("sb_wb", {63'd0, rs_busy[0]}, 64'h0);

    // Flush with concurrent alloc
    alloc_valid = 1'b1; alloc_rd = 5'd3; step();
    alloc_rd = 5'd4; step(); idle();
    a0 = 5'd3; a1 = 5'd4; #1;
    check("fl_pre", {62'd0, rs_busy}, 64'h3);
    flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd9; #1;
    check("fl_comb", {62'd0, rs_busy}, 64'h0);
    step(); idle(); #1;
    check("fl_x3x4", {62'd0, rs_busy}, 64'h0);
    check("fl_x3dat", rs_data[63:0], 64'h34);
    check("fl_x4dat", rs_data[127:64], 64'h0);
    a0 = 5'd9; #1;
    check("fl_x9", {63'd0, rs_busy[0]}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
